bch_dec_stream_encoder: RTL

//  Systematic encoder for the shortened double-error-correcting (DEC) BCH code.
//  - Datapath twin of the ROM-based error-pattern decoder.
//  - Accepts a P_D_WIDTH-bit message as P_BUS_WIDTH-bit beats, MSB first.
//  - Forwards the message beats unchanged, then appends fn_ecc_synd_width(P_D_WIDTH) parity bits.
//  - Parity is computed by an unrolled LFSR over g(x) of the GF(2^m) code chosen by fn_int_width().

---
 rtl/bch_dec_stream_encoder_pkg.sv | 36 +++
 rtl/bch_dec_stream_encoder_lfsr.sv | 26 ++
 rtl/bch_dec_stream_encoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bch_dec_stream_encoder_pkg.sv
// rtl/bch_dec_stream_encoder_pkg.sv - BCH code geometry and generator polynomial helpers
package bch_dec_stream_encoder_pkg;

   // Smallest field order m whose DEC BCH code fits the message plus 2m parity bits.
   function automatic int fn_gf_m(input int d_width);
      if (d_width + 10 <= 31)
         return 5;
      else if (d_width + 12 <= 63)
         return 6;
      else if (d_width + 14 <= 127)
         return 7;
      else
         return 8;
   endfunction

   // Natural (unshortened) code length n = 2^m - 1.
   function automatic int fn_int_width(input int d_width);
      return (1 << fn_gf_m(d_width)) - 1;
   endfunction

   // Parity width of the DEC code: two minimal polynomials of degree m.
   function automatic int fn_ecc_synd_width(input int d_width);
      return 2 * fn_gf_m(d_width);
   endfunction

   // g(x) = m1(x)*m3(x) with the leading x^2m term dropped, right aligned.
   function automatic logic [15:0] fn_bch_gen_poly(input int d_width);
      case (fn_gf_m(d_width))
         5:       return 16'h0369;
         6:       return 16'h0539;
         7:       return 16'h0377;
         default: return 16'h6F63;
      endcase
   endfunction

endpackage

// File: rtl/bch_dec_stream_encoder_lfsr.sv
// rtl/bch_dec_stream_encoder_lfsr.sv - unrolled multi-bit BCH parity LFSR update
module bch_lfsr_step #(
   parameter int              P_PW = 10,
   parameter int              P_BW = 2,
   parameter logic [P_PW-1:0] P_G  = '0
) (
   input  logic [P_PW-1:0] r_i,
   input  logic [P_BW-1:0] bits_i,
   output logic [P_PW-1:0] r_o
);

   logic [P_PW-1:0] r_tmp;
   logic            fb;

   // Divide by g(x) one bit at a time, earliest (MSB) input bit first.
   always_comb begin
      r_tmp = r_i;
      fb    = 1'b0;
      for (int i = P_BW - 1; i >= 0; i--) begin
         fb    = bits_i[i] ^ r_tmp[P_PW-1];
         r_tmp = {r_tmp[P_PW-2:0], 1'b0} ^ (fb ? P_G : '0);
      end
      r_o = r_tmp;
   end

endmodule

// File: rtl/bch_dec_stream_encoder.sv
// rtl/bch_dec_stream_encoder.sv - streaming systematic encoder for shortened DEC BCH codes
module bch_dec_stream_encoder
   import bch_dec_stream_encoder_pkg::*;
#(
   parameter int P_D_WIDTH   = 16,
   parameter int P_BUS_WIDTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [P_BUS_WIDTH-1:0] din_i,
   input  logic                   din_vld_i,
   output logic                   din_rdy_o,
   output logic [P_BUS_WIDTH-1:0] dout_o,
   output logic                   dout_vld_o,
   input  logic                   dout_rdy_i,
   output logic                   dout_last_o
);

   localparam int LP_N    = fn_int_width(P_D_WIDTH);
   localparam int LP_PW   = fn_ecc_synd_width(P_D_WIDTH);
   localparam int LP_DB   = P_D_WIDTH / P_BUS_WIDTH;
   localparam int LP_PB   = LP_PW / P_BUS_WIDTH;
   localparam int LP_CMAX = (LP_DB > LP_PB) ? LP_DB : LP_PB;
   localparam int LP_CW   = $clog2(LP_CMAX + 1);

   localparam logic [15:0]       LP_G_FULL  = fn_bch_gen_poly(P_D_WIDTH);
   localparam logic [LP_PW-1:0]  LP_G       = LP_G_FULL[LP_PW-1:0];
   localparam logic [LP_CW-1:0]  LP_DB_LAST = LP_CW'(LP_DB - 1);
   localparam logic [LP_CW-1:0]  LP_PB_LAST = LP_CW'(LP_PB - 1);

   generate
      if (!(P_BUS_WIDTH == 1 || P_BUS_WIDTH == 2) || (P_D_WIDTH % P_BUS_WIDTH != 0)
          || (P_D_WIDTH + LP_PW > LP_N)) begin : g_bad_param
         $error("bch_dec_stream_encoder: illegal P_D_WIDTH/P_BUS_WIDTH combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [LP_CW-1:0]       cnt_q, cnt_d;
   logic [LP_PW-1:0]       lfsr_q, lfsr_d;
   logic [LP_PW-1:0]       lfsr_step;
   logic [P_BUS_WIDTH-1:0] dout_q, dout_d;
   logic                   vld_q, vld_d;
   logic                   last_q, last_d;
   logic                   run_q;
   logic                   load_ok;
   logic                   din_rdy;

   bch_lfsr_step #(
      .P_PW (LP_PW),
      .P_BW (P_BUS_WIDTH),
      .P_G  (LP_G)
   ) u_lfsr_step (
      .r_i    (lfsr_q),
      .bits_i (din_i),
      .r_o    (lfsr_step)
   );

   // Holds din_rdy_o low while reset is asserted and for the first cycle after release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) run_q <= 1'b0;
      else          run_q <= 1'b1;
   end

   // Codeword FSM, beat counter, LFSR and output register next-state logic.
   always_comb begin
      load_ok = ~vld_q | dout_rdy_i;
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      dout_d  = dout_q;
      vld_d   = vld_q;
      last_d  = last_q;
      din_rdy = 1'b0;

      if (vld_q && dout_rdy_i) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // A stalled final parity beat may still occupy the output register.
            din_rdy = run_q & load_ok;
            if (din_vld_i && din_rdy) begin
               dout_d = din_i;
               vld_d  = 1'b1;
               last_d = 1'b0;
               lfsr_d = lfsr_step;
               if (LP_DB == 1) begin
                  state_d = ST_PARITY;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = LP_CW'(1);
               end
            end
         end
         ST_DATA: begin
            din_rdy = load_ok;
            if (din_vld_i && din_rdy) begin
               dout_d = din_i;
               vld_d  = 1'b1;
               last_d = 1'b0;
               lfsr_d = lfsr_step;
               if (cnt_q == LP_DB_LAST) begin
                  state_d = ST_PARITY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + LP_CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (load_ok) begin
               dout_d = lfsr_q[LP_PW-1 -: P_BUS_WIDTH];
               vld_d  = 1'b1;
               lfsr_d = lfsr_q << P_BUS_WIDTH;
               if (cnt_q == LP_PB_LAST) begin
                  last_d  = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  lfsr_d  = '0;
               end else begin
                  last_d = 1'b0;
                  cnt_d  = cnt_q + LP_CW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any codeword in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lfsr_q  <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
      end
   end

   assign din_rdy_o   = din_rdy;
   assign dout_o      = dout_q;
   assign dout_vld_o  = vld_q;
   assign dout_last_o = last_q;

endmodule
